pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Next-PC controller for the Pc register. Each cycle it selects PCNext and
//   drives PCen from stall, branch, jump, interrupt and return requests.
//   On every redirect it raises Flush for the fetch/decode stages. It also holds
//   the interrupt return address (EPC) and a one-level interrupt-active flag.
//   It sits between the control unit/hazard unit and the Pc register.
// PARAMETERS
//   PC_W          48      PC width; must match the Pc register
//   PC_INC        1       sequential increment added to PCResult
//   IRQ_VEC       48'h100 interrupt handler entry address
//   FLUSH_CYCLES  2       cycles Flush stays high after a redirect (>=1)
// PORTS
//   Clk           in   1     clock, rising edge
//   Reset         in   1     synchronous, active-high reset
//   PCResult      in   PC_W  current PC, taken from the Pc register output
//   Stall         in   1     hazard stall; holds the PC
//   BranchTaken   in   1     resolved taken branch this cycle
//   BranchTarget  in   PC_W  branch destination
//   Jump          in   1     unconditional jump this cycle
//   JumpTarget    in   PC_W  jump destination
//   IrqReq        in   1     level interrupt request
//   Eret          in   1     return-from-interrupt instruction
//   PCNext        out  PC_W  next PC to the Pc register (combinational)
//   PCen          out  1     Pc register load enable (combinational)
//   Flush         out  1     pipeline flush (registered)
//   IrqAck        out  1     1-cycle pulse when an interrupt is taken (combinational)
//   EPC           out  PC_W  saved return address (registered)
//   InIrq         out  1     handler active (registered)
// BEHAVIOUR
//   - Reset=1: PCen=0, IrqAck=0, PCNext=0 that cycle; at the edge Flush, EPC,
//     InIrq and the flush counter all clear to 0. Reset mid-flush or mid-handler
//     aborts the flush or handler completely.
//   - Event selection is priority-ordered; exactly one event acts per cycle:
//     1. IRQ    (IrqReq & !InIrq): PCNext=IRQ_VEC, PCen=1, IrqAck=1;
//               at the edge EPC<=PCResult and InIrq<=1.
//     2. JUMP   (Jump): PCNext=JumpTarget, PCen=1.
//     3. BRANCH (BranchTaken): PCNext=BranchTarget, PCen=1.
//     4. ERET   (Eret & InIrq): PCNext=EPC, PCen=1; InIrq<=0 at the edge.
//               Eret with InIrq=0 is ignored and falls through to 5/6.
//     5. STALL  (Stall): PCen=0, PCNext=PCResult.
//     6. SEQ:   PCNext=PCResult+PC_INC (mod 2^PC_W; wraps silently), PCen=1.
//   - Events 1-4 are redirects. Redirects override Stall.
//   - IrqReq while InIrq=1 is not accepted (no nesting). It stays pending and is
//     taken the first cycle after ERET clears InIrq.
//   - Flush FSM: states IDLE and FLUSH, with a counter cnt.
//       IDLE -> FLUSH on any redirect: Flush<=1, cnt<=FLUSH_CYCLES-1.
//       FLUSH: cnt decrements each cycle; at cnt==0 go to IDLE, Flush<=0.
//       A redirect during FLUSH reloads cnt (restarts the window).
//     Flush rises the edge after the redirect cycle and stays high exactly
//     FLUSH_CYCLES cycles.
//   - Stall during FLUSH freezes PCen but does not freeze cnt.
//   - Zero internal latency: PCNext/PCen are valid in the same cycle as the
//     inputs; the Pc register updates at the next edge.
// TESTING
//   1. Reset, then PCResult tracks PCNext, no events for 4 cycles
//      -> PC goes 0,1,2,3,4; Flush=0.
//   2. At PC=5 assert Stall for 3 cycles -> PCen=0 and PC stays 5;
//      release -> PC=6.
//   3. At PC=8 BranchTaken=1, BranchTarget=48'h40 -> PC=0x40 next;
//      Flush=1 for exactly 2 cycles.
//   4. Same cycle Jump (0x80), BranchTaken (0x40) and Stall -> PC=0x80;
//      jump wins and the stall is overridden.
//   5. At PC=0x21 IrqReq=1 -> IrqAck pulse, PC=0x100, EPC=0x21, InIrq=1;
//      second IrqReq ignored; Eret -> PC=0x21, InIrq=0.
//   6. PCResult=48'hFFFF_FFFF_FFFF with no events -> PCNext=0.
//      Assert Reset during FLUSH -> Flush=0 and InIrq=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks PCNext/PCen from priority-ordered redirect and stall
// requests, times the pipeline Flush window and tracks one level of interrupt state.
module pc_sequencer #(
    parameter int unsigned     PC_W         = 48,
    parameter int unsigned     PC_INC       = 1,
    parameter logic [PC_W-1:0] IRQ_VEC      = PC_W'('h100),
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [PC_W-1:0] PCResult,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [PC_W-1:0] BranchTarget,
    input  logic            Jump,
    input  logic [PC_W-1:0] JumpTarget,
    input  logic            IrqReq,
    input  logic            Eret,
    output logic [PC_W-1:0] PCNext,
    output logic            PCen,
    output logic            Flush,
    output logic            IrqAck,
    output logic [PC_W-1:0] EPC,
    output logic            InIrq
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             redirect;
    logic             irq_take;
    logic             eret_take;

    // Exactly one event acts per cycle; the if/else chain encodes the priority.
    always_comb begin
        PCNext    = PCResult + PC_W'(PC_INC);
        PCen      = 1'b1;
        IrqAck    = 1'b0;
        redirect  = 1'b0;
        irq_take  = 1'b0;
        eret_take = 1'b0;
        if (Reset) begin
            PCNext = '0;
            PCen   = 1'b0;
        end else if (IrqReq && !InIrq) begin
            PCNext   = IRQ_VEC;
            IrqAck   = 1'b1;
            irq_take = 1'b1;
            redirect = 1'b1;
        end else if (Jump) begin
            PCNext   = JumpTarget;
            redirect = 1'b1;
        end else if (BranchTaken) begin
            PCNext   = BranchTarget;
            redirect = 1'b1;
        end else if (Eret && InIrq) begin
            PCNext    = EPC;
            eret_take = 1'b1;
            redirect  = 1'b1;
        end else if (Stall) begin
            PCNext = PCResult;
            PCen   = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            Flush <= 1'b0;
            EPC   <= '0;
            InIrq <= 1'b0;
        end else begin
            if (irq_take) begin
                EPC   <= PCResult;
                InIrq <= 1'b1;
            end else if (eret_take) begin
                InIrq <= 1'b0;
            end

            // A redirect in either state (re)opens the full flush window.
            if (redirect) begin
                state <= FLUSH;
                Flush <= 1'b1;
                cnt   <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
                case (state)
                    FLUSH: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                            Flush <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        Flush <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [47:0] PCResult;
    logic        Stall;
    logic        BranchTaken;
    logic [47:0] BranchTarget;
    logic        Jump;
    logic [47:0] JumpTarget;
    logic        IrqReq;
    logic        Eret;
    logic [47:0] PCNext;
    logic        PCen;
    logic        Flush;
    logic        IrqAck;
    logic [47:0] EPC;
    logic        InIrq;

    pc_sequencer #(
        .PC_W        (48),
        .PC_INC      (1),
        .IRQ_VEC     (48'h100),
        .FLUSH_CYCLES(2)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PCResult    (PCResult),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump        (Jump),
        .JumpTarget  (JumpTarget),
        .IrqReq      (IrqReq),
        .Eret        (Eret),
        .PCNext      (PCNext),
        .PCen        (PCen),
        .Flush       (Flush),
        .IrqAck      (IrqAck),
        .EPC         (EPC),
        .InIrq       (InIrq)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          id;
        logic [47:0] pcnext;
        logic        pcen;
        logic        ack;
        logic        flush;
        logic [47:0] epc;
        logic        inirq;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input int id, input string field, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", id, field, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.id, "PCNext", PCNext, e.pcnext);
            chk(e.id, "PCen",   {47'd0, PCen},   {47'd0, e.pcen});
            chk(e.id, "IrqAck", {47'd0, IrqAck}, {47'd0, e.ack});
            chk(e.id, "Flush",  {47'd0, Flush},  {47'd0, e.flush});
            chk(e.id, "EPC",    EPC, e.epc);
            chk(e.id, "InIrq",  {47'd0, InIrq},  {47'd0, e.inirq});
        end
    end

    task automatic apply(
        input int id, input logic rst, input logic [47:0] pcr, input logic s,
        input logic b, input logic [47:0] bt, input logic j, input logic [47:0] jt,
        input logic i, input logic e,
        input logic [47:0] xpc, input logic xen, input logic xack, input logic xfl,
        input logic [47:0] xepc, input logic xin);
        exp_t x;
        @(posedge Clk);
        #1;
        Reset = rst; PCResult = pcr; Stall = s;
        BranchTaken = b; BranchTarget = bt; Jump = j; JumpTarget = jt;
        IrqReq = i; Eret = e;
        x.id = id; x.pcnext = xpc; x.pcen = xen; x.ack = xack;
        x.flush = xfl; x.epc = xepc; x.inirq = xin;
        q.push_back(x);
    endtask

    initial begin
        Reset = 1'b1; PCResult = '0; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = '0; Jump = 1'b0; JumpTarget = '0;
        IrqReq = 1'b0; Eret = 1'b0;
        repeat (2) @(posedge Clk);

        //     id rst pcr            s  b  bt     j  jt     i  e   pcnext         en ack fl epc    inirq
        apply( 1, 1, 48'h0,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h0,         0, 0, 0, 48'h0,  0);
        // sequential run 0..5
        apply( 2, 0, 48'h0,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h1,         1, 0, 0, 48'h0,  0);
        apply( 3, 0, 48'h1,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h2,         1, 0, 0, 48'h0,  0);
        apply( 4, 0, 48'h2,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h3,         1, 0, 0, 48'h0,  0);
        apply( 5, 0, 48'h3,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h4,         1, 0, 0, 48'h0,  0);
        apply( 6, 0, 48'h4,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h5,         1, 0, 0, 48'h0,  0);
        // stall three cycles at 5
        apply( 7, 0, 48'h5,          1, 0, 48'h0, 0, 48'h0, 0, 0,  48'h5,         0, 0, 0, 48'h0,  0);
        apply( 8, 0, 48'h5,          1, 0, 48'h0, 0, 48'h0, 0, 0,  48'h5,         0, 0, 0, 48'h0,  0);
        apply( 9, 0, 48'h5,          1, 0, 48'h0, 0, 48'h0, 0, 0,  48'h5,         0, 0, 0, 48'h0,  0);
        apply(10, 0, 48'h5,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h6,         1, 0, 0, 48'h0,  0);
        apply(11, 0, 48'h6,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h7,         1, 0, 0, 48'h0,  0);
        apply(12, 0, 48'h7,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h8,         1, 0, 0, 48'h0,  0);
        // branch at 8, Flush high exactly two cycles
        apply(13, 0, 48'h8,          0, 1, 48'h40,0, 48'h0, 0, 0,  48'h40,        1, 0, 0, 48'h0,  0);
        apply(14, 0, 48'h40,         0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h41,        1, 0, 1, 48'h0,  0);
        apply(15, 0, 48'h41,         0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h42,        1, 0, 1, 48'h0,  0);
        apply(16, 0, 48'h42,         0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h43,        1, 0, 0, 48'h0,  0);
        // jump beats branch and stall
        apply(17, 0, 48'h43,         1, 1, 48'h40,1, 48'h80,0, 0,  48'h80,        1, 0, 0, 48'h0,  0);
        apply(18, 0, 48'h80,         0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h81,        1, 0, 1, 48'h0,  0);
        // redirect on last flush cycle reloads the window
        apply(19, 0, 48'h81,         0, 0, 48'h0, 1, 48'h21,0, 0,  48'h21,        1, 0, 1, 48'h0,  0);
        // interrupt at 0x21, second request ignored, eret returns
        apply(20, 0, 48'h21,         0, 0, 48'h0, 0, 48'h0, 1, 0,  48'h100,       1, 1, 1, 48'h0,  0);
        apply(21, 0, 48'h100,        0, 0, 48'h0, 0, 48'h0, 1, 0,  48'h101,       1, 0, 1, 48'h21, 1);
        apply(22, 0, 48'h101,        1, 0, 48'h0, 0, 48'h0, 1, 0,  48'h101,       0, 0, 1, 48'h21, 1);
        apply(23, 0, 48'h101,        0, 0, 48'h0, 0, 48'h0, 1, 1,  48'h21,        1, 0, 0, 48'h21, 1);
        // pending request taken right after eret clears InIrq
        apply(24, 0, 48'h21,         0, 0, 48'h0, 0, 48'h0, 1, 0,  48'h100,       1, 1, 1, 48'h21, 0);
        apply(25, 0, 48'h100,        0, 0, 48'h0, 0, 48'h0, 0, 1,  48'h21,        1, 0, 1, 48'h21, 1);
        // eret outside a handler is ignored
        apply(26, 0, 48'h21,         0, 0, 48'h0, 0, 48'h0, 0, 1,  48'h22,        1, 0, 1, 48'h21, 0);
        // wrap-around
        apply(27, 0, 48'hFFFF_FFFF_FFFF, 0, 0, 48'h0, 0, 48'h0, 0, 0, 48'h0,      1, 0, 1, 48'h21, 0);
        apply(28, 0, 48'h0,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h1,         1, 0, 0, 48'h21, 0);
        // reset in the middle of flush and handler
        apply(29, 0, 48'h1,          0, 0, 48'h0, 0, 48'h0, 1, 0,  48'h100,       1, 1, 0, 48'h21, 0);
        apply(30, 1, 48'h100,        0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h0,         0, 0, 1, 48'h1,  1);
        apply(31, 0, 48'h0,          0, 0, 48'h0, 0, 48'h0, 0, 0,  48'h1,         1, 0, 0, 48'h0,  0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge Clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
